// File: rtl/demux14x16_reg.sv
// ---------------------------------------------------------------------------
// demux14x16_reg
//
// Registered 1-to-4 demultiplexer for datapath words. One word per cycle is
// accepted on a valid/ready input and steered by `cntrl` into one of four
// single-entry output buffers. Each buffer has its own valid/ready handshake,
// so a stalled destination only blocks traffic addressed to it.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   cntrl[1:0]  destination select, sampled with din when din_valid=1
//   din         input word (WIDTH bits)
//   din_valid   din/cntrl valid this cycle
//   din_ready   selected channel can take a word this cycle (combinational
//               from cntrl, dout_valid and dout_ready only)
//   dout0..3    channel holding registers (hold last value after drain)
//   dout_valid  bit N = doutN holds an undelivered word
//   dout_ready  bit N = consumer N takes doutN this cycle
//   xfer_cnt    16-bit accepted-word counter, wraps; present only when the
//               DEMUX_COUNT_EN macro is defined
// ---------------------------------------------------------------------------
module demux14x16_reg #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       cntrl,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic [WIDTH-1:0] dout0,
    output logic [WIDTH-1:0] dout1,
    output logic [WIDTH-1:0] dout2,
    output logic [WIDTH-1:0] dout3,
    output logic [3:0]       dout_valid,
    input  logic [3:0]       dout_ready
`ifdef DEMUX_COUNT_EN
    ,
    output logic [15:0]      xfer_cnt
`endif
);

    logic [WIDTH-1:0] data_p1 [4];
    logic [3:0]       vld_p1;
    logic             accept_p0;

    // Stage p0: selection and handshake (combinational). A full channel can
    // still take a word if its consumer drains it in the same cycle.
    always_comb begin
        din_ready = ~vld_p1[cntrl] | dout_ready[cntrl];
        accept_p0 = din_valid & din_ready;
    end

    // Stage p1: per-channel holding registers. Accept wins over drain so a
    // same-cycle drain+load keeps the valid bit high with no bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < 4; n++) begin
                data_p1[n] <= '0;
            end
            vld_p1 <= 4'b0000;
        end else begin
            for (int n = 0; n < 4; n++) begin
                if (accept_p0 && (cntrl == 2'(n))) begin
                    data_p1[n] <= din;
                    vld_p1[n]  <= 1'b1;
                end else if (vld_p1[n] && dout_ready[n]) begin
                    vld_p1[n]  <= 1'b0;
                end
            end
        end
    end

`ifdef DEMUX_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_cnt <= 16'h0000;
        end else if (accept_p0) begin
            xfer_cnt <= xfer_cnt + 16'h0001;
        end
    end
`endif

    assign dout0      = data_p1[0];
    assign dout1      = data_p1[1];
    assign dout2      = data_p1[2];
    assign dout3      = data_p1[3];
    assign dout_valid = vld_p1;

endmodule

// File: tb/tb_demux14x16_reg.sv
module tb_demux14x16_reg;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  cntrl = 2'd0;
    logic [15:0] din = 16'h0;
    logic        din_valid = 1'b0;
    logic        din_ready;
    logic [15:0] dout0, dout1, dout2, dout3;
    logic [3:0]  dout_valid;
    logic [3:0]  dout_ready = 4'b0000;
`ifdef DEMUX_COUNT_EN
    logic [15:0] xfer_cnt;
`endif

    int nchk = 0;
    int nerr = 0;
    bit chk_on = 1'b0;

    demux14x16_reg #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .cntrl(cntrl), .din(din),
        .din_valid(din_valid), .din_ready(din_ready),
        .dout0(dout0), .dout1(dout1), .dout2(dout2), .dout3(dout3),
        .dout_valid(dout_valid), .dout_ready(dout_ready)
`ifdef DEMUX_COUNT_EN
        , .xfer_cnt(xfer_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: each channel is a queue of undelivered words (at most
    // one), plus the last word ever written to it and a count of accepts.
    logic [15:0] mq [4][$];
    logic [15:0] mlast [4];
    int          mcnt = 0;

    function automatic bit exp_ready(input logic [1:0] c, input logic [3:0] rdy);
        return (mq[c].size() == 0) || rdy[c];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge rst_n) begin
        for (int n = 0; n < 4; n++) begin
            mq[n].delete();
            mlast[n] = 16'h0;
        end
        mcnt = 0;
    end

    always @(posedge clk) begin
        if (rst_n) begin
            bit acc;
            acc = din_valid && exp_ready(cntrl, dout_ready);
            for (int n = 0; n < 4; n++)
                if (mq[n].size() != 0 && dout_ready[n]) void'(mq[n].pop_front());
            if (acc) begin
                mq[cntrl].push_back(din);
                mlast[cntrl] = din;
                mcnt = (mcnt + 1) % 65536;
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_on && rst_n) begin
            logic [15:0] act [4];
            act[0] = dout0; act[1] = dout1; act[2] = dout2; act[3] = dout3;
            for (int n = 0; n < 4; n++) begin
                check($sformatf("cyc_vld%0d", n), 32'(dout_valid[n]), 32'(mq[n].size() != 0));
                check($sformatf("cyc_dout%0d", n), 32'(act[n]), 32'(mlast[n]));
                if (mq[n].size() > 1) check("cyc_qdepth", 32'(mq[n].size()), 32'd1);
            end
            check("cyc_din_ready", 32'(din_ready), 32'(exp_ready(cntrl, dout_ready)));
`ifdef DEMUX_COUNT_EN
            check("cyc_xfer_cnt", 32'(xfer_cnt), 32'(mcnt));
`endif
        end
    end

    // Advance to just after the next rising edge, where inputs are driven.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Mid-cycle point for directed checks.
    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] c, input logic [15:0] d);
        cntrl = c; din = d; din_valid = 1'b1;
        step();
        din_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_dout_valid", 32'(dout_valid), 32'h0);
        check("rst_dout2", 32'(dout2), 32'h0);
`ifdef DEMUX_COUNT_EN
        check("rst_xfer_cnt", 32'(xfer_cnt), 32'h0);
`endif
        #1 rst_n = 1'b1;
    endtask

    int stalls;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("init_dout_valid", 32'(dout_valid), 32'h0);
        check("init_dout0", 32'(dout0), 32'h0);
        rst_n = 1'b1;
        chk_on = 1'b1;
        step();

        // Reset mid-stream after loading ch2.
        dout_ready = 4'b0000;
        send(2'd2, 16'hBEEF);
        mid();
        check("ld_dout2", 32'(dout2), 32'hBEEF);
        check("ld_vld", 32'(dout_valid), 32'h4);
        pulse_reset();
        step();

        // Backpressure on ch1, ch3 pre-filled and stalled.
        send(2'd3, 16'h3333);
        send(2'd1, 16'h1111);
        cntrl = 2'd1; din = 16'h2222; din_valid = 1'b1;
        #1 check("bp_ch1_stall", 32'(din_ready), 32'h0);
        step();
        check("bp_ch1_hold", 32'(dout1), 32'h1111);
        cntrl = 2'd3; din = 16'h4444;
        #1 check("bp_ch3_refused", 32'(din_ready), 32'h0);
        step();
        cntrl = 2'd1; din = 16'h2222; dout_ready = 4'b0010;
        #1 check("bp_release_ready", 32'(din_ready), 32'h1);
        step();
        din_valid = 1'b0; dout_ready = 4'b0000;
        check("bp_dout1", 32'(dout1), 32'h2222);
        check("bp_vld", 32'(dout_valid), 32'hA);

        // Simultaneous drain and load on ch0.
        send(2'd0, 16'h0F0F);
        cntrl = 2'd0; din = 16'hA5A5; din_valid = 1'b1; dout_ready = 4'b0001;
        step();
        din_valid = 1'b0; dout_ready = 4'b0000;
        check("dl_dout0", 32'(dout0), 32'hA5A5);
        check("dl_vld0", 32'(dout_valid[0]), 32'h1);

        // Independence: all full, drain ch1 and ch3 only.
        send(2'd2, 16'h2A2A);
        check("ind_full", 32'(dout_valid), 32'hF);
        dout_ready = 4'b1010;
        cntrl = 2'd1;
        #1 check("ind_c1_ready", 32'(din_ready), 32'h1);
        cntrl = 2'd0;
        #1 check("ind_c0_ready", 32'(din_ready), 32'h0);
        step();
        dout_ready = 4'b0000;
        check("ind_vld", 32'(dout_valid), 32'h5);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            cntrl = 2'($urandom_range(0, 3));
            din = 16'($urandom);
            din_valid = 1'($urandom_range(0, 3) != 0);
            dout_ready = 4'($urandom);
            step();
        end

        // Full sweep with all consumers ready; counter should wrap to zero.
        din_valid = 1'b0; dout_ready = 4'b1111;
        step();
        pulse_reset();
        step();
        stalls = 0;
        for (int i = 0; i < 65536; i++) begin
            cntrl = 2'(i); din = 16'(i); din_valid = 1'b1;
            #1 if (!din_ready) stalls++;
            step();
        end
        din_valid = 1'b0;
        check("sweep_stalls", 32'(stalls), 32'h0);
        check("sweep_dout3", 32'(dout3), 32'hFFFF);
        check("sweep_dout0", 32'(dout0), 32'hFFFC);
`ifdef DEMUX_COUNT_EN
        check("sweep_wrap", 32'(xfer_cnt), 32'h0);
`endif
        mid();
        chk_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
